decode_sched: RTL and testbench



---
 rtl/pipes.sv | 48 ++++
 rtl/decode_sched_table.sv | 82 ++++++++
 rtl/decode_sched.sv | 124 ++++++++++++
 tb/tb_decode_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// Shared types for the decode scheduler: FSM states, operand-source select,
// and the in-flight table entry, plus the per-entry match helper.
package pipes;

    localparam int unsigned REG_AW  = 5;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HAZ   = 2'd2,
        ST_REDIR = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic              is_load;
    } inflight_t;

    // A used source hits an entry only if that entry really writes a
    // non-zero register; x0 is hard-wired and never produces a dependency.
    function automatic logic src_hit(input inflight_t ent,
                                     input logic [REG_AW-1:0] ra,
                                     input logic used);
        return used && ent.valid && ent.rd_we &&
               (ent.rd != '0) && (ent.rd == ra);
    endfunction

    // Youngest producer wins: execute, then memory, then writeback.
    function automatic fwd_sel_t pick_src(input logic hit_e,
                                          input logic hit_m,
                                          input logic hit_w);
        if (hit_e)      return FWD_EX;
        else if (hit_m) return FWD_MEM;
        else if (hit_w) return FWD_WB;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/decode_sched_table.sv
// Three-entry in-flight table (execute, memory, writeback) with source
// match, forwarding priority and hazard detection.
// Macro DECODE_SCHED_FWD_EN: defined -> forward from E/M/W and stall only on
// load-use; undefined -> no forwarding, stall on any in-flight match.
module decode_sched_table
    import pipes::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              shift_en,
    input  inflight_t         ent_in,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              use1,
    input  logic              use2,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b,
    output logic              hazard
);

    inflight_t e_q, m_q, w_q;
    inflight_t e_d, m_d, w_d;

    logic hit_a_e, hit_a_m, hit_a_w;
    logic hit_b_e, hit_b_m, hit_b_w;
    logic unused_load_bits;

    // Advance the pipeline image only when the back end moves.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (shift_en) begin
            w_d = m_q;
            m_d = e_q;
            e_d = ent_in;
        end
    end

    // Table registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the table is only three entries, so each is cleared on reset; a stale valid bit would fake a hazard.
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            // NOTE: non-blocking so all entries shift from their pre-edge values.
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign hit_a_e = src_hit(e_q, ra1, use1);
    assign hit_a_m = src_hit(m_q, ra1, use1);
    assign hit_a_w = src_hit(w_q, ra1, use1);
    assign hit_b_e = src_hit(e_q, ra2, use2);
    assign hit_b_m = src_hit(m_q, ra2, use2);
    assign hit_b_w = src_hit(w_q, ra2, use2);

    // Only the load flag in E matters to the forwarding policy.
    assign unused_load_bits = m_q.is_load ^ w_q.is_load ^ e_q.is_load;

    // Operand source selection and hazard decision.
    always_comb begin
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        hazard = 1'b0;
`ifdef DECODE_SCHED_FWD_EN
        fwd_a  = pick_src(hit_a_e, hit_a_m, hit_a_w);
        fwd_b  = pick_src(hit_b_e, hit_b_m, hit_b_w);
        // Load data is not ready until memory, so a consumer right behind a
        // load has to wait one cycle and then take it from M.
        hazard = (hit_a_e | hit_b_e) & e_q.is_load;
`else
        hazard = hit_a_e | hit_a_m | hit_a_w | hit_b_e | hit_b_m | hit_b_w;
`endif
    end

endmodule

// File: rtl/decode_sched.sv
// Decode/issue scheduler: FSM, issue/stall/flush control and the hazard
// cycle counter around the in-flight table.
// Macro DECODE_SCHED_FWD_EN selects forwarding (defined) or stall-only
// (undefined) hazard handling; see decode_sched_table.
module decode_sched
    import pipes::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              use1,
    input  logic              use2,
    input  logic [REG_AW-1:0] rd,
    input  logic              rd_we,
    input  logic              is_load,
    input  logic              ex_ready,
    input  logic              redirect,
    output logic              issue_valid,
    output logic              stall_f,
    output logic              flush_d,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [31:0]       hazard_cnt
);

    sched_state_t state_q, state_d;
    logic [31:0]  hazard_cnt_q, hazard_cnt_d;

    inflight_t ent_in;
    fwd_sel_t  fwd_a_sel, fwd_b_sel;
    logic      tbl_hazard;
    logic      data_haz;
    logic      count_haz;

    // Whatever issues this cycle becomes the new E entry; otherwise a bubble.
    assign ent_in.valid   = issue_valid;
    assign ent_in.rd      = rd;
    assign ent_in.rd_we   = rd_we;
    assign ent_in.is_load = is_load;

    decode_sched_table u_table (
        .clk      (clk),
        .resetn   (resetn),
        .shift_en (ex_ready),
        .ent_in   (ent_in),
        .ra1      (ra1),
        .ra2      (ra2),
        .use1     (use1),
        .use2     (use2),
        .fwd_a    (fwd_a_sel),
        .fwd_b    (fwd_b_sel),
        .hazard   (tbl_hazard)
    );

    assign fwd_a    = fwd_a_sel;
    assign fwd_b    = fwd_b_sel;
    assign data_haz = dec_valid & tbl_hazard;

    // Next state and control outputs: redirect beats a frozen back end,
    // which beats a data hazard. IDLE ignores everything so nothing leaks
    // out while reset is held or in the first cycle after release.
    always_comb begin
        state_d     = state_q;
        issue_valid = 1'b0;
        stall_f     = 1'b0;
        flush_d     = 1'b0;
        count_haz   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_REDIR: begin
                if (redirect) begin
                    flush_d = 1'b1;
                    state_d = ST_REDIR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HAZ: begin
                if (redirect) begin
                    flush_d = 1'b1;
                    state_d = ST_REDIR;
                end else if (!ex_ready) begin
                    stall_f = 1'b1;
                end else if (data_haz) begin
                    stall_f   = 1'b1;
                    count_haz = 1'b1;
                    state_d   = ST_HAZ;
                end else begin
                    issue_valid = dec_valid;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hazard cycle counter, saturating at all-ones.
    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if (count_haz && (hazard_cnt_q != CNT_MAX)) begin
            hazard_cnt_d = hazard_cnt_q + 32'd1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            hazard_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_decode_sched.sv
// Scoreboard bench for decode_sched. Each cycle's stimulus pushes its
// expected outputs; a negedge monitor pops and compares them.
// Expectations follow DECODE_SCHED_FWD_EN as defined for the build.
module tb_decode_sched;

    typedef struct {
        string       tag;
        logic        iv;
        logic        st;
        logic        fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        dec_valid;
    logic [4:0]  ra1, ra2, rd;
    logic        use1, use2, rd_we, is_load;
    logic        ex_ready, redirect;
    logic        issue_valid, stall_f, flush_d;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] hazard_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    decode_sched dut (
        .clk         (clk),
        .resetn      (resetn),
        .dec_valid   (dec_valid),
        .ra1         (ra1),
        .ra2         (ra2),
        .use1        (use1),
        .use2        (use2),
        .rd          (rd),
        .rd_we       (rd_we),
        .is_load     (is_load),
        .ex_ready    (ex_ready),
        .redirect    (redirect),
        .issue_valid (issue_valid),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .hazard_cnt  (hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge and queue what the
    // outputs must show before the next one.
    task automatic cyc(input string tag, input logic rn, input logic dv,
                       input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2,
                       input logic [4:0] d, input logic we, input logic ld,
                       input logic exr, input logic rdr,
                       input logic eiv, input logic est, input logic efl,
                       input logic [1:0] efa, input logic [1:0] efb,
                       input logic [31:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        resetn    = rn;
        dec_valid = dv;
        ra1       = a1;
        use1      = u1;
        ra2       = a2;
        use2      = u2;
        rd        = d;
        rd_we     = we;
        is_load   = ld;
        ex_ready  = exr;
        redirect  = rdr;
        e.tag = tag;
        e.iv  = eiv;
        e.st  = est;
        e.fl  = efl;
        e.fa  = efa;
        e.fb  = efb;
        e.cnt = ecnt;
        sb.push_back(e);
    endtask

    // Monitor: compare settled outputs at the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".issue_valid"}, 32'(issue_valid), 32'(e.iv));
            check({e.tag, ".stall_f"},     32'(stall_f),     32'(e.st));
            check({e.tag, ".flush_d"},     32'(flush_d),     32'(e.fl));
            check({e.tag, ".fwd_a"},       32'(fwd_a),       32'(e.fa));
            check({e.tag, ".fwd_b"},       32'(fwd_b),       32'(e.fb));
            check({e.tag, ".hazard_cnt"},  hazard_cnt,       e.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; dec_valid = 1'b0; ra1 = '0; ra2 = '0; rd = '0;
        use1 = 1'b0; use2 = 1'b0; rd_we = 1'b0; is_load = 1'b0;
        ex_ready = 1'b1; redirect = 1'b0;

        //  tag          rn dv  a1 u1  a2 u2  rd we ld  exr rdr  iv st fl  fa fb  cnt
        cyc("rst0",       0, 1,  5, 1,  5, 1,  5, 1, 1,  1, 0,   0, 0, 0,  0, 0,  0);
        cyc("rst1",       0, 1,  5, 1,  5, 1,  5, 1, 1,  0, 0,   0, 0, 0,  0, 0,  0);
        cyc("idle",       1, 1,  5, 1,  0, 0,  5, 1, 0,  1, 0,   0, 0, 0,  0, 0,  0);
`ifdef DECODE_SCHED_FWD_EN
        cyc("addi_x5",    1, 1,  1, 1,  0, 0,  5, 1, 0,  1, 0,   1, 0, 0,  0, 0,  0);
        cyc("fwd_ex",     1, 1,  5, 1,  1, 1,  6, 1, 0,  1, 0,   1, 0, 0,  1, 0,  0);
        cyc("fwd_mem_ex", 1, 1,  5, 1,  6, 1,  7, 1, 0,  1, 0,   1, 0, 0,  2, 1,  0);
        cyc("fwd_wb",     1, 1,  5, 1,  0, 1,  0, 1, 0,  1, 0,   1, 0, 0,  3, 0,  0);
        cyc("ld_x7",      1, 1,  6, 1,  0, 0,  7, 1, 1,  1, 0,   1, 0, 0,  3, 0,  0);
        cyc("ld_use",     1, 1,  7, 1,  2, 1,  8, 1, 0,  1, 0,   0, 1, 0,  1, 0,  0);
        cyc("ld_fwd_mem", 1, 1,  7, 1,  2, 1,  8, 1, 0,  1, 0,   1, 0, 0,  2, 0,  1);
        cyc("wr_x0",      1, 1,  8, 1,  0, 0,  0, 1, 0,  1, 0,   1, 0, 0,  1, 0,  1);
        cyc("rd_x0",      1, 1,  0, 1,  0, 1,  9, 1, 0,  1, 0,   1, 0, 0,  0, 0,  1);
        for (int i = 0; i < 3; i++)
            cyc("freeze", 1, 1,  9, 1,  8, 1,  1, 1, 0,  0, 0,   0, 1, 0,  1, 3,  1);
        cyc("ld_x11",     1, 1,  0, 0,  0, 0, 11, 1, 1,  1, 0,   1, 0, 0,  0, 0,  1);
        cyc("haz_x11",    1, 1, 11, 1,  0, 0,  1, 1, 0,  1, 0,   0, 1, 0,  1, 0,  1);
        cyc("redir_haz",  1, 1, 11, 1,  0, 0,  1, 1, 0,  1, 1,   0, 0, 1,  2, 0,  2);
        cyc("redir_st",   1, 1, 11, 1,  0, 0,  1, 1, 0,  1, 0,   0, 0, 0,  3, 0,  2);
        cyc("run_again",  1, 1, 11, 1,  0, 0,  1, 1, 0,  1, 0,   1, 0, 0,  0, 0,  2);
        cyc("ld_x12",     1, 1,  0, 0,  0, 0, 12, 1, 1,  1, 0,   1, 0, 0,  0, 0,  2);
        cyc("haz_x12",    1, 1, 12, 1,  0, 0,  1, 1, 0,  1, 0,   0, 1, 0,  1, 0,  2);
        cyc("rst_in_haz", 0, 1, 12, 1,  0, 0,  1, 1, 0,  1, 0,   0, 0, 0,  0, 0,  0);
        cyc("rel_idle",   1, 1, 12, 1,  0, 0,  1, 1, 0,  1, 0,   0, 0, 0,  0, 0,  0);
        cyc("rel_run",    1, 1, 12, 1,  0, 0,  1, 1, 0,  1, 0,   1, 0, 0,  0, 0,  0);
`else
        cyc("addi_x5",    1, 1,  1, 1,  0, 0,  5, 1, 0,  1, 0,   1, 0, 0,  0, 0,  0);
        cyc("stall_e",    1, 1,  5, 1,  1, 1,  6, 1, 0,  1, 0,   0, 1, 0,  0, 0,  0);
        cyc("stall_m",    1, 1,  5, 1,  1, 1,  6, 1, 0,  1, 0,   0, 1, 0,  0, 0,  1);
        cyc("stall_w",    1, 1,  5, 1,  1, 1,  6, 1, 0,  1, 0,   0, 1, 0,  0, 0,  2);
        cyc("issue_add",  1, 1,  5, 1,  1, 1,  6, 1, 0,  1, 0,   1, 0, 0,  0, 0,  3);
        cyc("wr_x0",      1, 1,  1, 1,  0, 0,  0, 1, 0,  1, 0,   1, 0, 0,  0, 0,  3);
        cyc("rd_x0",      1, 1,  0, 1,  0, 1,  7, 1, 0,  1, 0,   1, 0, 0,  0, 0,  3);
        for (int i = 0; i < 3; i++)
            cyc("freeze", 1, 1,  9, 1,  0, 0,  9, 1, 0,  0, 0,   0, 1, 0,  0, 0,  3);
        cyc("frozen_hit", 1, 1,  7, 1,  0, 0,  9, 1, 0,  1, 0,   0, 1, 0,  0, 0,  3);
        cyc("redir_haz",  1, 1,  7, 1,  0, 0,  9, 1, 0,  1, 1,   0, 0, 1,  0, 0,  4);
        cyc("redir_st",   1, 1,  3, 1,  0, 0,  0, 0, 0,  1, 0,   0, 0, 0,  0, 0,  4);
        cyc("run_again",  1, 1,  3, 1,  0, 0,  0, 0, 0,  1, 0,   1, 0, 0,  0, 0,  4);
        cyc("ld_x10",     1, 1,  3, 1,  0, 0, 10, 1, 1,  1, 0,   1, 0, 0,  0, 0,  4);
        cyc("haz_x10",    1, 1, 10, 1,  0, 0,  1, 1, 0,  1, 0,   0, 1, 0,  0, 0,  4);
        cyc("rst_in_haz", 0, 1, 10, 1,  0, 0,  1, 1, 0,  1, 0,   0, 0, 0,  0, 0,  0);
        cyc("rel_idle",   1, 1, 10, 1,  0, 0,  1, 1, 0,  1, 0,   0, 0, 0,  0, 0,  0);
        cyc("rel_run",    1, 1, 10, 1,  0, 0,  1, 1, 0,  1, 0,   1, 0, 0,  0, 0,  0);
`endif
        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
